event_priority_encoder: RTL and testbench
=========================================

Name: event_priority_encoder

Overview:
- Parametrised, registered successor to the team's combinational 4-to-2 one-hot encoder.
- Accepts N independent event-request lines and latches each event in a sticky pending set. Emits one binary index per accepted transfer over a valid/ready handshake.
- Supports a fixed-priority mode and a round-robin mode.
- Sits between interrupt/event sources and a single consumer, e.g. an interrupt controller or a DMA channel scheduler.

Parameters:
- N, 8: number of request lines; legal range 1..64.
- W, max(1, clog2(N)): width of the index output. Derived; do not override.
- RR, 0: selection mode. 0 = fixed priority, lowest index wins. 1 = round-robin.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  event requests; each high cycle is one event on that line.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
- out_valid  output  1  out_idx holds an event; registered.
- out_idx  output  W  binary index of the event being offered; registered.
- pending  output  N  events latched but not yet loaded into the output register; registered.
- overflow  output  1  sticky flag: at least one event was coalesced; registered.

Behaviour:
- Reset: when rst is high at an edge, pending=0, out_valid=0, out_idx=0, overflow=0, and the RR pointer ptr=0. req is ignored on that edge. Reset mid-transfer drops all events, including an unaccepted out_idx.
- Definitions:
  - accept = out_valid && out_ready.
  - load = !out_valid || accept.
  - held = onehot(out_idx) when out_valid && !out_ready, else 0.
  - cand = pending | req.
- Coalescing: req[i] while pending[i]=1 or held[i]=1 is coalesced. It is not queued a second time, and overflow is set to 1 until rst. A req[i] on the same cycle as that index's accept is a fresh event, not coalesced.
- Selection when load && cand != 0:
  - Fixed mode: sel = lowest set bit of cand.
  - RR mode: sel = first set bit of cand searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - At the edge: out_valid<=1, out_idx<=sel, pending<=cand & ~onehot(sel).
  - RR mode only: ptr<=(sel+1) mod N, wrapping N-1 -> 0.
- load && cand == 0: out_valid<=0, pending unchanged (0); out_idx holds its last value.
- !load (stalled): out_valid and out_idx hold, stable while ready is low. pending<=pending | (req & ~held).
- Latency: req on cycle t with the output free gives out_valid=1 on cycle t+1. One index per cycle under continuous out_ready=1.
- No preemption: an offered index is never replaced before accept, even by a higher-priority request.
- N=1: W=1, out_idx always 0, and RR mode degenerates to fixed mode.
- Index arithmetic is unsigned and modulo N. The fixed and RR searches must be synthesisable as a loop or a double-width mask; no latches are allowed.

Test Plan:
1. Reset: N=8, req=8'hFF held with rst=1 for 3 cycles, then release with req=0 -> out_valid=0, pending=0, overflow=0 after release.
2. Fixed, single event: req=8'b0000_0100 for one cycle, out_ready=1 -> next cycle out_valid=1, out_idx=2; the cycle after, out_valid=0, pending=0.
3. Fixed, burst: req=8'h91 for one cycle, out_ready=1 -> out_idx 0, 4, 7 on three consecutive cycles, out_valid then drops; pending goes 8'h90, 8'h80, 0.
4. Backpressure, no preemption:
   - Stimulus: out_ready=0, req=8'h80 at cycle 0, then req=8'h01 at cycle 2; raise out_ready at cycle 5.
   - Required: out_idx=7 stable on cycles 1-5, then 0 on cycle 6, with pending=8'h01 during the stall.
5. Round-robin, RR=1: req=8'hFF held every cycle, out_ready=1 -> out_idx 0,1,2,...,7,0,1 in order, and overflow=1 from the second cycle onward.
6. Coalescing: out_ready=0, req[3] pulsed at cycles 0 and 2; raise out_ready at cycle 4 for one cycle -> exactly one transfer with out_idx=3, overflow=1, pending stays 0.

Source files
------------

// File: rtl/event_priority_encoder.sv
// Event priority encoder. Latches request pulses into a sticky pending set and
// hands out one binary index per valid/ready transfer. It can run in
// fixed-priority mode (lowest index wins) or in round-robin mode.
// Each output is registered. A request that arrives while its event is still
// queued or still being offered is merged with that event and sets overflow.
module event_priority_encoder #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] pend_q, pend_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         load;
  logic [N-1:0] held;
  logic [N-1:0] cand;
  logic [W-1:0] start;
  logic [W-1:0] lo_sel;
  logic [W-1:0] hi_sel;
  logic         hi_found;
  logic [W-1:0] sel;

  assign accept = valid_q & out_ready;
  assign load   = ~valid_q | accept;
  // An offered index counts as still live only while the consumer stalls it.
  assign held   = (valid_q && !out_ready) ? (N'(1) << idx_q) : '0;
  assign cand   = pend_q | req;
  // Fixed mode behaves like round-robin with the pointer tied to zero.
  assign start  = (RR != 0) ? ptr_q : '0;

  // Round-robin search split into two passes. The first pass finds the lowest
  // candidate at or above start. The second finds the lowest candidate overall,
  // which is the wrap-around case.
  always_comb begin
    lo_sel   = '0;
    hi_sel   = '0;
    hi_found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_sel = W'(i);
        if (i >= int'(start)) begin
          hi_sel   = W'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  // Next-state logic for the output register, the pending set, the overflow
  // flag and the round-robin pointer.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q | (|(req & (pend_q | held)));
    if (load) begin
      if (|cand) begin
        valid_d = 1'b1;
        idx_d   = sel;
        pend_d  = cand & ~(N'(1) << sel);
        if (RR != 0) begin
          ptr_d = (32'(sel) == N - 1) ? '0 : sel + W'(1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      // While stalled the offered index stays fixed and new events queue up.
      pend_d = pend_q | (req & ~held);
    end
  end

  // State registers, with a synchronous reset that drops every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_event_priority_encoder.sv
// Bench for event_priority_encoder. It runs a fixed-priority instance and a
// round-robin instance side by side on the same stimulus. Each instance is
// checked every cycle against its own behavioural model, and the bench also
// makes directed checks with hand-computed values.
module tb_event_priority_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;

  logic       vf, vr;
  logic [2:0] idxf, idxr;
  logic [7:0] pf, pr;
  logic       ovff, ovfr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  event_priority_encoder #(.N(8), .RR(0)) u_fix (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .out_ready(out_ready),
    .out_valid(vf),
    .out_idx  (idxf),
    .pending  (pf),
    .overflow (ovff)
  );

  event_priority_encoder #(.N(8), .RR(1)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .out_ready(out_ready),
    .out_valid(vr),
    .out_idx  (idxr),
    .pending  (pr),
    .overflow (ovfr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Index 0 is fixed priority and index 1 is round-robin.
  bit mvalid[2];
  int midx[2];
  bit mpend[2][8];
  bit movf[2];
  int mptr[2];
  bit live = 1'b0;

  task automatic model_step(input int d);
    bit stall;
    bit is_held;
    bit cand[8];
    int best;
    int bestkey;
    int key;
    if (rst) begin
      mvalid[d] = 1'b0;
      midx[d]   = 0;
      movf[d]   = 1'b0;
      mptr[d]   = 0;
      for (int i = 0; i < 8; i++) mpend[d][i] = 1'b0;
      return;
    end
    stall = mvalid[d] && !out_ready;
    for (int i = 0; i < 8; i++) begin
      is_held = stall && (midx[d] == i);
      if (req[i] && (mpend[d][i] || is_held)) movf[d] = 1'b1;
      cand[i] = mpend[d][i] | req[i];
      if (stall && req[i] && !is_held) mpend[d][i] = 1'b1;
    end
    if (stall) return;
    best    = -1;
    bestkey = 99;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) begin
        // Round-robin ranks a candidate by its distance from the pointer.
        key = (d == 1) ? (i - mptr[d] + 8) % 8 : i;
        if (key < bestkey) begin
          bestkey = key;
          best    = i;
        end
      end
    end
    if (best >= 0) begin
      mvalid[d] = 1'b1;
      midx[d]   = best;
      if (d == 1) mptr[d] = (best + 1) % 8;
    end else begin
      mvalid[d] = 1'b0;
    end
    for (int i = 0; i < 8; i++) mpend[d][i] = cand[i] && (i != best);
  endtask

  function automatic logic [7:0] mpack(input int d);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v[i] = mpend[d][i];
    return v;
  endfunction

  // Advance the model on each active edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
    if (rst) live = 1'b1;
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("fix_valid", vf, mvalid[0]);
      chk("fix_idx", idxf, midx[0]);
      chk("fix_pending", pf, mpack(0));
      chk("fix_overflow", ovff, movf[0]);
      chk("rr_valid", vr, mvalid[1]);
      chk("rr_idx", idxr, midx[1]);
      chk("rr_pending", pr, mpack(1));
      chk("rr_overflow", ovfr, movf[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset: requests are ignored while rst is high.
    rst = 1'b1;
    req = 8'hFF;
    repeat (3) step();
    chk("t1_valid_in_rst", vf, 0);
    chk("t1_pending_in_rst", pf, 8'h00);
    rst = 1'b0;
    req = 8'h00;
    step();
    chk("t1_valid", vf, 0);
    chk("t1_pending", pf, 8'h00);
    chk("t1_overflow", ovff, 0);

    // Fixed priority, single event.
    out_ready = 1'b1;
    req = 8'b0000_0100;
    step();
    req = 8'h00;
    chk("t2_valid", vf, 1);
    chk("t2_idx", idxf, 2);
    step();
    chk("t2_valid_drop", vf, 0);
    chk("t2_pending", pf, 8'h00);

    // Fixed priority, burst of three events.
    req = 8'h91;
    step();
    req = 8'h00;
    chk("t3_idx0", idxf, 0);
    chk("t3_pend0", pf, 8'h90);
    step();
    chk("t3_idx1", idxf, 4);
    chk("t3_pend1", pf, 8'h80);
    step();
    chk("t3_idx2", idxf, 7);
    chk("t3_pend2", pf, 8'h00);
    step();
    chk("t3_valid_drop", vf, 0);

    // Backpressure with no preemption.
    out_ready = 1'b0;
    req = 8'h80;
    step();
    req = 8'h00;
    chk("t4_idx_c1", idxf, 7);
    step();
    chk("t4_idx_c2", idxf, 7);
    req = 8'h01;
    step();
    req = 8'h00;
    chk("t4_idx_c3", idxf, 7);
    chk("t4_pend_c3", pf, 8'h01);
    step();
    chk("t4_idx_c4", idxf, 7);
    step();
    chk("t4_idx_c5", idxf, 7);
    chk("t4_pend_c5", pf, 8'h01);
    out_ready = 1'b1;
    step();
    chk("t4_valid_c6", vf, 1);
    chk("t4_idx_c6", idxf, 0);
    chk("t4_pend_c6", pf, 8'h00);
    step();
    chk("t4_valid_c7", vf, 0);

    // Coalescing while the same index is still being offered.
    do_reset();
    out_ready = 1'b0;
    req = 8'h08;
    step();
    req = 8'h00;
    chk("t6_idx", idxf, 3);
    chk("t6_ovf_before", ovff, 0);
    step();
    req = 8'h08;
    step();
    req = 8'h00;
    chk("t6_ovf", ovff, 1);
    chk("t6_pend", pf, 8'h00);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_valid_after", vf, 0);
    chk("t6_pend_after", pf, 8'h00);
    chk("t6_ovf_after", ovff, 1);
    step();
    chk("t6_valid_end", vf, 0);

    // Round-robin with every line requesting on every cycle.
    do_reset();
    out_ready = 1'b1;
    req = 8'hFF;
    step();
    chk("t5_idx_0", idxr, 0);
    chk("t5_ovf_0", ovfr, 0);
    for (int k = 1; k < 10; k++) begin
      step();
      chk("t5_idx", idxr, k % 8);
      chk("t5_valid", vr, 1);
      chk("t5_ovf", ovfr, 1);
    end
    chk("t5_fix_idx", idxf, 0);
    req = 8'h00;
    repeat (10) step();
    chk("t5_drain", vr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
